// File: rtl/hazard_stall_unit.sv
// Load-use stall, branch flush and memory-busy freeze control for the 5-stage pipeline.
// Optional macro HAZARD_PERF_COUNTERS_EN adds stall_cycles / flush_cycles counters.
module hazard_stall_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int TIMEOUT      = 255,
  parameter int TMO_W        = 8,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [18:0] IF_ID_instruction,
  input  logic [18:0] ID_EX_instruction,
  input  logic        branch_taken_EX,
  input  logic        mem_busy,
  output logic        pc_write,
  output logic        IF_ID_write,
  output logic        IF_ID_flush,
  output logic        ID_EX_bubble,
  output logic        freeze_all,
  output logic        mem_timeout,
  output logic [1:0]  state
`ifdef HAZARD_PERF_COUNTERS_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
`endif
);

  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, MEM_WAIT = 2'd2} state_e;

  localparam logic [1:0] FCNT_INIT = 2'(FLUSH_CYCLES - 1);
  localparam logic [4:0] OP_LW = 5'b10000;
  localparam logic [4:0] OP_SW = 5'b10001;

  state_e           state_q, state_d;
  logic [1:0]       fcnt_q, fcnt_d;
  logic [TMO_W-1:0] wdog_q, wdog_d;
  logic             tmo_q, tmo_d;

  logic [4:0] id_op, ex_op;
  logic [2:0] id_dst, id_a, id_b, ex_dst;
  logic       id_alu, id_imm, id_lw, id_sw, ex_lw, load_use;
  logic       unused_ok;

  assign id_op  = IF_ID_instruction[18:14];
  assign id_dst = IF_ID_instruction[13:11];
  assign id_a   = IF_ID_instruction[10:8];
  assign id_b   = IF_ID_instruction[7:5];
  assign ex_op  = ID_EX_instruction[18:14];
  assign ex_dst = ID_EX_instruction[13:11];
  assign id_alu = ~id_op[4];
  assign id_imm = IF_ID_instruction[17];
  assign id_lw  = (id_op == OP_LW);
  assign id_sw  = (id_op == OP_SW);
  assign ex_lw  = (ex_op == OP_LW);

  // A stores its data register in the dst field, so a sw consumes dst as a source.
  assign load_use = ex_lw && (ex_dst != 3'd0) &&
                    (((id_alu || id_lw || id_sw) && (id_a == ex_dst)) ||
                     (id_alu && !id_imm && (id_b == ex_dst)) ||
                     (id_sw && (id_dst == ex_dst)));

  assign unused_ok = ^{IF_ID_instruction[4:0], ID_EX_instruction[10:0], 1'(CNT_W)};

  always_comb begin
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    freeze_all   = 1'b0;
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    if (!rst) begin
      if (mem_busy) begin
        freeze_all  = 1'b1;
        pc_write    = 1'b0;
        IF_ID_write = 1'b0;
        if (state_q != FLUSH) state_d = MEM_WAIT;
      end else if (state_q == FLUSH) begin
        IF_ID_flush = 1'b1;
        fcnt_d      = fcnt_q - 2'd1;
        if (fcnt_q == 2'd1) state_d = RUN;
      end else if (branch_taken_EX) begin
        IF_ID_flush  = 1'b1;
        ID_EX_bubble = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d = FLUSH;
          fcnt_d  = FCNT_INIT;
        end else begin
          state_d = RUN;
        end
      end else begin
        // Single-cycle stall: afterwards the lw is in MEM and is forwarded.
        if (load_use) begin
          pc_write     = 1'b0;
          IF_ID_write  = 1'b0;
          ID_EX_bubble = 1'b1;
        end
        state_d = RUN;
      end
    end
  end

  always_comb begin
    wdog_d = '0;
    if (mem_busy) wdog_d = (wdog_q == '1) ? wdog_q : wdog_q + 1'b1;
    tmo_d = tmo_q | (mem_busy && (wdog_d >= TMO_W'(TIMEOUT)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      wdog_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      wdog_q  <= wdog_d;
      tmo_q   <= tmo_d;
    end
  end

  assign mem_timeout = tmo_q & ~rst;
  assign state       = rst ? RUN : state_q;

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [CNT_W-1:0] stall_q, stall_d, flushc_q, flushc_d;

  always_comb begin
    stall_d  = stall_q;
    flushc_d = flushc_q;
    if (!pc_write && stall_q != '1)     stall_d  = stall_q + 1'b1;
    if (IF_ID_flush && flushc_q != '1)  flushc_d = flushc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      flushc_q <= '0;
    end else begin
      stall_q  <= stall_d;
      flushc_q <= flushc_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_cycles = flushc_q;
`endif

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Upstream complement of the forwarding unit: handles hazards that forwarding cannot resolve, by stalling or flushing the 5-stage pipeline.
- Detects load-use dependencies between ID and EX (19-bit instruction format); squashes wrong-path fetches after a taken branch resolved in EX.
- Freezes the whole pipeline while data memory is busy, with a watchdog on that wait.
- Drives the write enables and bubble/flush controls of the PC and the IF/ID and ID/EX registers.

Parameters:
- FLUSH_CYCLES, 2: cycles IF/ID is squashed after a taken branch; legal range 1..4.
- TIMEOUT, 255: consecutive mem_busy cycles after which mem_timeout sets.
- TMO_W, 8: watchdog counter width; TIMEOUT < 2^TMO_W.
- CNT_W, 16: performance counter width (optional feature only).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- IF_ID_instruction  in  19  instruction in ID
- ID_EX_instruction  in  19  instruction in EX
- branch_taken_EX  in  1  taken branch resolved in EX this cycle
- mem_busy  in  1  data memory not ready; pipeline must hold
- pc_write  out  1  PC update enable
- IF_ID_write  out  1  IF/ID load enable
- IF_ID_flush  out  1  load NOP into IF/ID
- ID_EX_bubble  out  1  load NOP into ID/EX
- freeze_all  out  1  hold every pipeline register, including EX/MEM and MEM/WB
- mem_timeout  out  1  sticky watchdog error
- state  out  2  FSM state for debug: RUN=0, FLUSH=1, MEM_WAIT=2

Behaviour:
- Field decode: op=[18:14], dst=[13:11], A=[10:8], B=[7:5]. ALU when op[4]=0; immediate when bit17=1; lw op=10000; sw op=10001.
- load_use = ID_EX is lw, ID_EX.dst!=0, and ID reads that register:
  - A field, when ID is ALU, lw or sw;
  - B field, when ID is ALU and not immediate;
  - dst field, when ID is sw (store data).
- Outputs are combinational from state and inputs; state, flush counter, watchdog and mem_timeout are registered.
- Defaults: pc_write=1, IF_ID_write=1; all other outputs 0.
- While rst=1: outputs at defaults, mem_timeout=0. Next edge: state=RUN, counters cleared.
- Priority each cycle: mem_busy > branch_taken_EX > load_use.
- RUN:
  - mem_busy=1: freeze_all=1, pc_write=0, IF_ID_write=0; next state MEM_WAIT.
  - else branch_taken_EX=1: IF_ID_flush=1, ID_EX_bubble=1. If FLUSH_CYCLES>1, next state FLUSH with fcnt=FLUSH_CYCLES-1.
  - else load_use: pc_write=0, IF_ID_write=0, ID_EX_bubble=1, for exactly one cycle. After that cycle the lw sits in MEM and the forwarding unit covers it, so no re-detection occurs.
- FLUSH:
  - IF_ID_flush=1; fcnt decrements; when fcnt reaches 0, next state RUN.
  - mem_busy=1 overrides: freeze_all=1, pc_write=0, IF_ID_write=0, IF_ID_flush=0; fcnt holds; state stays FLUSH.
  - load_use is ignored in FLUSH (ID holds a squashed NOP).
- MEM_WAIT:
  - mem_busy=1: freeze outputs as in RUN.
  - mem_busy=0: evaluate exactly as RUN this cycle, including branch and load_use; next state per the RUN rules.
- Watchdog:
  - Increments on every cycle with mem_busy=1, in any state, and saturates.
  - Clears on any cycle with mem_busy=0.
  - When it reaches TIMEOUT, mem_timeout sets and stays set until rst.
  - The freeze continues regardless; no recovery action is taken.
- Reset asserted mid-FLUSH or mid-MEM_WAIT aborts the operation with no residual flush or freeze.

Optional Feature:
- Macro HAZARD_PERF_COUNTERS_EN.
- Defined: adds outputs stall_cycles[CNT_W-1:0] and flush_cycles[CNT_W-1:0].
  - stall_cycles counts cycles with pc_write=0; flush_cycles counts cycles with IF_ID_flush=1.
  - Both saturate at all-ones and reset to 0.
- Undefined: neither port nor logic exists; all other behaviour is identical.

Test Plan:
- ID_EX = lw dst=3; IF_ID = ALU R-type A=3 -> one cycle with pc_write=0, IF_ID_write=0, ID_EX_bubble=1; next cycle all at defaults.
- ID_EX = lw dst=0; IF_ID reads r0 -> no stall. ID_EX = lw dst=2; IF_ID immediate ALU with B=2, A=5 -> no stall. IF_ID = sw with dst=2 -> stall.
- branch_taken_EX pulse, FLUSH_CYCLES=2 -> IF_ID_flush=1 for 2 cycles, ID_EX_bubble=1 on the first only; state sequence 0,1,0.
- Same cycle: branch_taken_EX=1 and load_use=1 -> flush only, no pc_write deassert. mem_busy=1 also asserted -> freeze_all=1 only.
- mem_busy high for 256 cycles, TIMEOUT=255 -> mem_timeout rises after the 255th busy cycle and stays high after mem_busy drops; clears only on rst.
- rst asserted during FLUSH -> next cycle state=0, IF_ID_flush=0. With macro defined, 3 load-use stalls -> stall_cycles=3.
